mem_integration_block: RTL and testbench

MEM_INTEGRATION_BLOCK -- requirements
Module: mem_integration

---
 rtl/mem_integration_block.sv | 67 ++++++
 tb/tb_mem_integration_block.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mem_integration_block.sv
// MEM stage: DEPTH x 32 data memory plus the MEM/WB pipeline register.
// Define DMEM_ADDR_CHECK_EN to suppress misaligned or out-of-range accesses.
module mem_integration_block #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        EX_RegWrite,
    input  logic        EX_MemtoReg,
    input  logic        EX_MemRead,
    input  logic        EX_MemWrite,
    input  logic [31:0] EX_ALUResult,
    input  logic [31:0] EX_WriteData,
    input  logic [4:0]  EX_WriteReg,
    output logic [1:0]  WB_OUT,
    output logic [31:0] READ_DATA_OUT,
    output logic [31:0] ALU_RESULT_OUT,
    output logic [4:0]  WRITE_REG_OUT
);

    logic [31:0]   mem [DEPTH] = '{default: '0};
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic          store_en;
    logic          load_en;

    assign idx     = EX_ALUResult[AW+1:2];
    assign rd_word = mem[idx];

`ifdef DMEM_ADDR_CHECK_EN
    logic addr_ok;

    assign addr_ok  = (EX_ALUResult[1:0] == 2'b00) &&
                      (EX_ALUResult[31:AW+2] == '0);
    assign store_en = EX_MemWrite && addr_ok;
    assign load_en  = EX_MemRead && addr_ok;
`else
    // Byte-offset and high address bits are don't-care: accesses wrap.
    logic unused_addr;

    assign unused_addr = ^{EX_ALUResult[1:0], EX_ALUResult[31:AW+2]};
    assign store_en    = EX_MemWrite;
    assign load_en     = EX_MemRead;
`endif

    always_ff @(posedge Clk) begin
        if (!Rst && store_en) begin
            mem[idx] <= EX_WriteData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            WB_OUT         <= 2'b00;
            READ_DATA_OUT  <= 32'h0;
            ALU_RESULT_OUT <= 32'h0;
            WRITE_REG_OUT  <= 5'd0;
        end else begin
            WB_OUT         <= {EX_RegWrite, EX_MemtoReg};
            READ_DATA_OUT  <= load_en ? rd_word : 32'h0;
            ALU_RESULT_OUT <= EX_ALUResult;
            WRITE_REG_OUT  <= EX_WriteReg;
        end
    end

endmodule

// File: tb/tb_mem_integration_block.sv
// Scoreboard bench for mem_integration_block: a reference memory model
// predicts each cycle's MEM/WB contents, which are checked one cycle later.
module tb_mem_integration_block;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        EX_RegWrite;
    logic        EX_MemtoReg;
    logic        EX_MemRead;
    logic        EX_MemWrite;
    logic [31:0] EX_ALUResult;
    logic [31:0] EX_WriteData;
    logic [4:0]  EX_WriteReg;
    logic [1:0]  WB_OUT;
    logic [31:0] READ_DATA_OUT;
    logic [31:0] ALU_RESULT_OUT;
    logic [4:0]  WRITE_REG_OUT;

    typedef struct {
        logic [1:0]  wb;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] ref_mem [DEPTH];
    int          checks = 0;
    int          errors = 0;

    mem_integration_block #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Clk(Clk),
        .Rst(Rst),
        .EX_RegWrite(EX_RegWrite),
        .EX_MemtoReg(EX_MemtoReg),
        .EX_MemRead(EX_MemRead),
        .EX_MemWrite(EX_MemWrite),
        .EX_ALUResult(EX_ALUResult),
        .EX_WriteData(EX_WriteData),
        .EX_WriteReg(EX_WriteReg),
        .WB_OUT(WB_OUT),
        .READ_DATA_OUT(READ_DATA_OUT),
        .ALU_RESULT_OUT(ALU_RESULT_OUT),
        .WRITE_REG_OUT(WRITE_REG_OUT)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one operation, predict its result, clock it, then compare.
    task automatic op(input string tag, input logic rst, input logic rw,
                      input logic m2r, input logic rd, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [4:0] wreg);
        exp_t e;
        exp_t got;
        logic ok;
        logic [AW-1:0] i;
        Rst          = rst;
        EX_RegWrite  = rw;
        EX_MemtoReg  = m2r;
        EX_MemRead   = rd;
        EX_MemWrite  = wr;
        EX_ALUResult = addr;
        EX_WriteData = wdata;
        EX_WriteReg  = wreg;
        i  = addr[AW+1:2];
        ok = 1'b1;
`ifdef DMEM_ADDR_CHECK_EN
        ok = (addr[1:0] == 2'b00) && (addr < 32'(4 * DEPTH));
`endif
        if (rst) begin
            e = '{wb: 2'b00, rd: 32'h0, alu: 32'h0, wr: 5'd0};
        end else begin
            e.wb  = {rw, m2r};
            e.rd  = (rd && ok) ? ref_mem[i] : 32'h0;
            e.alu = addr;
            e.wr  = wreg;
            if (wr && ok) ref_mem[i] = wdata;
        end
        sb_q.push_back(e);
        @(posedge Clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            check({tag, "_wb"},  32'(WB_OUT),         32'(got.wb));
            check({tag, "_rd"},  READ_DATA_OUT,       got.rd);
            check({tag, "_alu"}, ALU_RESULT_OUT,      got.alu);
            check({tag, "_wr"},  32'(WRITE_REG_OUT),  32'(got.wr));
        end
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = 32'h0;

        op("rst0", 1, 1, 1, 1, 1, 32'h0000_0010, 32'h1357_9BDF, 5'd3);
        op("rst1", 1, 1, 0, 1, 1, 32'h0000_0088, 32'h0BAD_0BAD, 5'd7);

        op("st10", 0, 0, 0, 0, 1, 32'h10, 32'hDEAD_BEEF, 5'd0);
        op("ld10", 0, 1, 1, 1, 0, 32'h10, 32'h0, 5'd4);
        check("ld10_direct", READ_DATA_OUT, 32'hDEAD_BEEF);

        op("pass", 0, 1, 0, 0, 0, 32'h1234, 32'h0, 5'd9);
        check("pass_wb", 32'(WB_OUT), 32'h2);

        op("st20a", 0, 0, 0, 0, 1, 32'h20, 32'h1111_1111, 5'd0);
        op("rbw",   0, 1, 1, 1, 1, 32'h20, 32'h2222_2222, 5'd5);
        check("rbw_direct", READ_DATA_OUT, 32'h1111_1111);
        op("rbw_nx", 0, 1, 1, 1, 0, 32'h20, 32'h0, 5'd5);
        check("rbw_nx_direct", READ_DATA_OUT, 32'h2222_2222);

        op("rstst", 1, 0, 0, 0, 1, 32'h40, 32'hCAFE_F00D, 5'd0);
        op("ld40",  0, 1, 1, 1, 0, 32'h40, 32'h0, 5'd6);
        check("ld40_direct", READ_DATA_OUT, 32'h0);

        op("st400", 0, 0, 0, 0, 1, 32'h400, 32'hA5A5_A5A5, 5'd0);
        op("ld0",   0, 1, 1, 1, 0, 32'h0, 32'h0, 5'd1);
        op("ld401", 0, 1, 1, 1, 0, 32'h401, 32'h0, 5'd2);

        op("mid_a", 0, 1, 1, 1, 0, 32'h10, 32'h0, 5'd8);
        op("mid_r", 1, 1, 1, 1, 1, 32'h14, 32'h7777_7777, 5'd8);
        op("mid_b", 0, 1, 1, 1, 0, 32'h14, 32'h0, 5'd8);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = {$urandom_range(0, 3) == 0 ? 22'($urandom) : 22'd0,
                 4'd0, 4'($urandom), 2'($urandom_range(0, 4) == 0 ? 1 : 0)};
            op("rnd", $urandom_range(0, 19) == 0, 1'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), a,
               $urandom, 5'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
